// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back bundle, decode read ports and debug outputs of wb_regfile
//   master: drives wb_wd/wb_wreg/wb_wdata, wb_hi/wb_lo/wb_whilo, re1/raddr1, re2/raddr2
//   slave : returns rdata1, rdata2, hi_o, lo_o, wb_cnt
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              wb_whilo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [CNT_W-1:0]  wb_cnt;
  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, wb_cnt
  );
  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, wb_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back GPR file + HI/LO pair with same-cycle bypass and commit counter
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : wb_regfile_if slave (write-back bundle in, two read ports, hi_o/lo_o, wb_cnt out)
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] gpr_q [N];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we;
  logic              byp1, byp2;
  // r0 writes are dropped entirely, so they neither store nor count
  assign we = bus.wb_wreg && (bus.wb_wd != '0);
  always_comb begin
    hi_d  = bus.wb_whilo ? bus.wb_hi : hi_q;
    lo_d  = bus.wb_whilo ? bus.wb_lo : lo_q;
    cnt_d = cnt_q + CNT_W'(we);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < N; i++) gpr_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (we) gpr_q[bus.wb_wd] <= bus.wb_wdata;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  // bypass only matters for nonzero addresses; address 0 is forced to 0 first
  assign byp1 = bus.wb_wreg && (bus.wb_wd == bus.raddr1);
  assign byp2 = bus.wb_wreg && (bus.wb_wd == bus.raddr2);
  always_comb begin
    bus.rdata1 = (!rst || bus.raddr1 == '0 || !bus.re1) ? '0 :
                 byp1 ? bus.wb_wdata : gpr_q[bus.raddr1];
    bus.rdata2 = (!rst || bus.raddr2 == '0 || !bus.re2) ? '0 :
                 byp2 ? bus.wb_wdata : gpr_q[bus.raddr2];
    // hi_d/lo_d already carry the HI/LO bypass
    bus.hi_o   = rst ? hi_d : '0;
    bus.lo_o   = rst ? lo_d : '0;
    bus.wb_cnt = cnt_q;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven, scoreboarded check of wb_regfile (CNT_W=4 to reach counter wrap)
module tb_wb_regfile;
  localparam int DW = 32, AW = 5, CW = 4;
  typedef struct {
    logic          wreg;
    logic [AW-1:0] wd;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi, lo;
    logic          re1;
    logic [AW-1:0] ra1;
    logic          re2;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e1, e2, ehi, elo;
    logic [CW-1:0] ecnt;
  } vec_t;
  logic clk = 0, rst = 0;
  int total = 0, bad = 0;
  vec_t sb[$];
  vec_t tbl[12];
  wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic wreg, input logic [AW-1:0] wd, input logic [DW-1:0] wdata,
                              input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                              input logic re1, input logic [AW-1:0] ra1,
                              input logic re2, input logic [AW-1:0] ra2,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                              input logic [DW-1:0] ehi, input logic [DW-1:0] elo,
                              input logic [CW-1:0] ecnt);
    vec_t v;
    v.wreg = wreg; v.wd = wd; v.wdata = wdata; v.whilo = whilo; v.hi = hi; v.lo = lo;
    v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
    v.e1 = e1; v.e2 = e2; v.ehi = ehi; v.elo = elo; v.ecnt = ecnt;
    return v;
  endfunction
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.wb_wreg = v.wreg; bus.wb_wd = v.wd; bus.wb_wdata = v.wdata;
    bus.wb_whilo = v.whilo; bus.wb_hi = v.hi; bus.wb_lo = v.lo;
    bus.re1 = v.re1; bus.raddr1 = v.ra1; bus.re2 = v.re2; bus.raddr2 = v.ra2;
  endtask
  // drive on the falling edge, compare 2 time units later, well before the next rising edge
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    #2;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, ".rdata1"}, bus.rdata1, e.e1);
      check({name, ".rdata2"}, bus.rdata2, e.e2);
      check({name, ".hi_o"}, bus.hi_o, e.ehi);
      check({name, ".lo_o"}, bus.lo_o, e.elo);
      check({name, ".wb_cnt"}, DW'(bus.wb_cnt), DW'(e.ecnt));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    // under reset: outputs forced to 0 and a write + HI/LO write are ignored
    drive(mk(1, 7, 32'hAAAA, 1, 32'h5, 32'h6, 1, 7, 1, 7, 0, 0, 0, 0, 0));
    #2;
    check("rst.rdata1", bus.rdata1, 0);
    check("rst.rdata2", bus.rdata2, 0);
    check("rst.hi_o", bus.hi_o, 0);
    check("rst.lo_o", bus.lo_o, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 32'hDEADBEEF, 0, 0, 0, 1);
    tbl[3]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 32'hDEADBEEF, 0, 0, 1);
    tbl[5]  = mk(1, 3, 32'h33, 1, 32'h11, 32'h22, 1, 3, 0, 0, 32'h33, 0, 32'h11, 32'h22, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h33, 0, 32'h11, 32'h22, 2);
    tbl[7]  = mk(0, 3, 32'hBAD, 0, 32'h99, 32'h98, 1, 3, 0, 0, 32'h33, 0, 32'h11, 32'h22, 2);
    tbl[8]  = mk(1, 5, 32'h55, 0, 0, 0, 1, 5, 1, 5, 32'h55, 32'h55, 32'h11, 32'h22, 2);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 3, 32'h55, 0, 32'h11, 32'h22, 3);
    tbl[10] = mk(1, 5, 32'h66, 0, 0, 0, 0, 5, 1, 5, 0, 32'h66, 32'h11, 32'h22, 3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 3, 32'h66, 32'h33, 32'h11, 32'h22, 4);
    for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i]);
    // counter wrap: 11 writes take it from 4 to 15, the next write wraps to 0
    for (int i = 0; i < 11; i++)
      apply($sformatf("wrap%0d", i), mk(1, AW'(1 + i % 4), DW'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'h22, CW'(4 + i)));
    apply("wrap_full", mk(1, 2, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'h22, 15));
    apply("wrap_zero", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'h22, 0));
    // mid-run asynchronous reset after writing r7
    apply("w7", mk(1, 7, 32'h1234, 0, 0, 0, 1, 7, 0, 0, 32'h1234, 0, 32'h11, 32'h22, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_rst.rdata1", bus.rdata1, 32'h1234);
    check("pre_rst.wb_cnt", DW'(bus.wb_cnt), 1);
    #1 rst = 0;
    #1;
    check("async_rst.rdata1", bus.rdata1, 0);
    check("async_rst.wb_cnt", DW'(bus.wb_cnt), 0);
    check("async_rst.hi_o", bus.hi_o, 0);
    check("async_rst.lo_o", bus.lo_o, 0);
    drive(mk(1, 7, 32'hABCD, 1, 32'h77, 32'h78, 1, 7, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_byp.rdata1", bus.rdata1, 0);
    check("rst_byp.hi_o", bus.hi_o, 0);
    @(negedge clk);
    rst = 1;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check("post_rst.rdata1", bus.rdata1, 0);
    check("post_rst.wb_cnt", DW'(bus.wb_cnt), 0);
    check("post_rst.hi_o", bus.hi_o, 0);
    check("post_rst.lo_o", bus.lo_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back sink of the pipeline. Consumes the write-back-stage bundle: GPR write address/enable/data plus HI/LO values and HI/LO write enable.
- Commits that bundle into the architectural general-purpose register file and the HI/LO pair.
- Serves two read ports to the decode stage, with same-cycle write-to-read bypass.
- Exposes the current HI/LO values and a committed-write counter for debug.

Parameters:
DATA_W, 32, width of GPR, HI, LO and write data
ADDR_W, 5, GPR address width; register count = 2**ADDR_W
CNT_W, 32, width of the committed-write counter

Ports:
clk  in  1  clock, rising edge active
rst  in  1  asynchronous, active-low reset (rst==0 resets)
wb_wd  in  ADDR_W  GPR write address from write-back stage
wb_wreg  in  1  GPR write enable
wb_wdata  in  DATA_W  GPR write data
wb_hi  in  DATA_W  HI write value
wb_lo  in  DATA_W  LO write value
wb_whilo  in  1  HI/LO write enable (writes both together)
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data
hi_o  out  DATA_W  current HI, HI/LO bypass applied
lo_o  out  DATA_W  current LO, HI/LO bypass applied
wb_cnt  out  CNT_W  number of GPR writes committed since reset

Behaviour:
- Reset (rst==0, asynchronous):
  - all GPRs, HI, LO and wb_cnt clear to 0 immediately, without waiting for a clock edge.
  - While rst==0: rdata1, rdata2, hi_o and lo_o are forced to 0 and all writes are ignored.
  - Reset asserted in the same cycle as a write: the write is lost; the register remains 0.
- GPR write:
  - on rising clk with rst==1, wb_wreg==1 and wb_wd!=0, GPR[wb_wd] <= wb_wdata.
  - Writes to address 0 are discarded; GPR[0] reads as 0 always.
- GPR read (combinational, zero latency); priority, highest first:
  - 1) rst==0 -> 0
  - 2) raddrN==0 -> 0
  - 3) reN==1, wb_wreg==1 and wb_wd==raddrN -> wb_wdata (bypass of the write landing at this edge)
  - 4) reN==1 -> GPR[raddrN]
  - 5) reN==0 -> 0
  - Both ports may read the same address, or the bypassed address, in the same cycle; both return identical data.
- HI/LO:
  - on rising clk with rst==1 and wb_whilo==1, HI <= wb_hi and LO <= wb_lo, both together.
  - hi_o/lo_o are combinational: wb_hi/wb_lo while wb_whilo==1, otherwise the stored HI/LO.
  - HI/LO writes are independent of GPR writes; both may occur in the same cycle.
- Counter:
  - wb_cnt increments by 1 on each edge that commits a GPR write (wb_wreg==1, wb_wd!=0).
  - Discarded r0 writes and HI/LO-only writes do not count.
  - Wraps modulo 2**CNT_W (all-ones + 1 -> 0), no saturation.
- Timing:
  - Write-to-stored latency is 1 edge.
  - Read-after-write in the same cycle is satisfied by the bypass, so the decode stage needs no extra stall for write-back hazards.
- X-safety: with wb_wreg==0, wb_wd/wb_wdata are don't-care and never alter state.

Test Plan:
- Reset release, then re1=1 raddr1=7 -> rdata1=0. Pulse rst low mid-run after writing r7=0x1234 -> rdata1=0 immediately and after release; wb_cnt=0.
- Write r5=0xDEADBEEF (wb_wreg=1 wb_wd=5) with re1=1 raddr1=5 in the same cycle -> rdata1=0xDEADBEEF before the edge (bypass). After the edge with wb_wreg=0 -> still 0xDEADBEEF. wb_cnt=1.
- Write r0=0xFFFFFFFF -> raddr1=0 and raddr2=0 both return 0; wb_cnt unchanged.
- wb_whilo=1, wb_hi=0x11, wb_lo=0x22 -> hi_o=0x11, lo_o=0x22 in the same cycle. After the edge with wb_whilo=0, the same values are held. Simultaneous GPR write r3=0x33 -> both commit; wb_cnt increments by 1 only.
- re2=0, raddr2=5 (r5 holds 0xDEADBEEF) -> rdata2=0. Both ports at r5 with a concurrent write of 0x55 -> both read 0x55.
- Preload wb_cnt to all-ones via 2**CNT_W-1 writes (or a bench force with CNT_W=4: 15 writes), then one more write -> wb_cnt=0.
